// File: rtl/key_service_ctrl.sv
// Key PIO service controller: arms the PIO interrupt mask, services key interrupts,
// debounces with a holdoff window and queues key events in a small FWFT FIFO.
//
// state   | meaning
// INIT    | write IRQ_MASK to the PIO interrupt-mask register
// IDLE    | wait for pio_irq
// RD_ADDR | issue read of edge_capture
// RD_DATA | capture registered read data into evt_reg
// CLEAR   | write 0 to edge_capture
// PUSH    | queue evt_reg if nonzero, or flag overflow
// HOLD    | debounce lockout, pio_irq ignored
// FLUSH   | clear edges captured during HOLD
module key_service_ctrl #(
  parameter logic [3:0] IRQ_MASK       = 4'hF,
  parameter int         HOLDOFF_CYCLES = 50000,
  parameter int         FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        pio_irq,
  output logic        evt_valid,
  output logic [3:0]  evt_keys,
  input  logic        evt_ready,
  output logic        overflow,
  output logic        busy
);

  localparam int          PW         = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HOLD_LOAD  = (HOLDOFF_CYCLES <= 1) ? 16'd0 : 16'(HOLDOFF_CYCLES - 1);
  localparam logic [PW:0] FULL_COUNT = FIFO_DEPTH[PW:0];

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_RD_ADDR, S_RD_DATA, S_CLEAR, S_PUSH, S_HOLD, S_FLUSH
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  evt_reg;
  logic [15:0] hold_cnt;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push_req, full, pop, push, drop;

  logic unused_rd;
  assign unused_rd = ^avm_readdata[31:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
      evt_reg  <= 4'd0;
      hold_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == S_RD_DATA) evt_reg <= avm_readdata[3:0];
      if (state == S_PUSH) hold_cnt <= HOLD_LOAD;
      else if (state == S_HOLD && hold_cnt != 16'd0) hold_cnt <= hold_cnt - 16'd1;
    end
  end

  always_comb begin
    state_nxt      = state;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 2'd0;
    avm_writedata  = 32'd0;
    case (state)
      S_INIT: begin
        state_nxt = S_IDLE;
        if (!reset) begin
          avm_chipselect = 1'b1;
          avm_write_n    = 1'b0;
          avm_address    = 2'd2;
          avm_writedata  = {28'd0, IRQ_MASK};
        end
      end
      S_IDLE:    if (pio_irq) state_nxt = S_RD_ADDR;
      S_RD_ADDR: begin
        state_nxt      = S_RD_DATA;
        avm_chipselect = 1'b1;
        avm_address    = 2'd3;
      end
      S_RD_DATA: state_nxt = S_CLEAR;
      S_CLEAR, S_FLUSH: begin
        state_nxt      = (state == S_CLEAR) ? S_PUSH : S_IDLE;
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 2'd3;
      end
      S_PUSH:    state_nxt = S_HOLD;
      S_HOLD:    if (hold_cnt == 16'd0) state_nxt = S_FLUSH;
      default:   state_nxt = S_INIT;
    endcase
  end

  assign busy = (state != S_IDLE);

  // A pop frees the head slot this cycle, so a full FIFO may still accept a push.
  assign evt_valid = (count != '0);
  assign evt_keys  = evt_valid ? mem[rd_ptr] : 4'd0;
  assign pop       = evt_valid & evt_ready;
  assign full      = (count == FULL_COUNT);
  assign push_req  = (state == S_PUSH) && (evt_reg != 4'd0);
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= evt_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

endmodule
